// File: rtl/encoder83_serial_pkg.sv
// encoder83_serial_pkg: shared widths, FSM state encoding and popcount helper
package encoder83_serial_pkg;
    localparam int VEC_W  = 8;
    localparam int CODE_W = 3;
    typedef enum logic {ST_IDLE = 1'b0, ST_EMIT = 1'b1} state_t;
    function automatic logic [3:0] popcount8(input logic [VEC_W-1:0] v);
        popcount8 = '0;
        for (int i = 0; i < VEC_W; i++) popcount8 += 4'(v[i]);
    endfunction
endpackage

// File: rtl/encoder83_serial_if.sv
// encoder83_serial_if: vector-in / index-out valid-ready handshake bundle
interface encoder83_serial_if;
    import encoder83_serial_pkg::*;
    logic              in_valid;
    logic [VEC_W-1:0]  in_vec;
    logic              in_ready;
    logic              out_valid;
    logic [CODE_W-1:0] out_code;
    logic              out_last;
    logic              out_ready;
    logic              zero_flag;
    logic [3:0]        pop_cnt;
    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_code, out_last, zero_flag, pop_cnt
    );
    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_code, out_last, zero_flag, pop_cnt
    );
endinterface

// File: rtl/encoder83_serial_prio_enc8.sv
// prio_enc8: combinational priority encoder picking the lowest or highest set bit
module prio_enc8
    import encoder83_serial_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic [VEC_W-1:0]  i_pend,
    output logic [CODE_W-1:0] o_code,
    output logic [VEC_W-1:0]  o_mask,
    output logic              o_single
);
    // Scan away from the winning end so the last hit is the highest-priority bit
    always_comb begin
        o_code = '0;
        for (int i = 0; i < VEC_W; i++)
            if (i_pend[LSB_FIRST ? VEC_W-1-i : i]) o_code = CODE_W'(LSB_FIRST ? VEC_W-1-i : i);
    end
    assign o_mask   = VEC_W'(1) << o_code;
    assign o_single = (i_pend != '0) && ((i_pend & (i_pend - VEC_W'(1))) == '0);
endmodule

// File: rtl/encoder83_serial.sv
// encoder83_serial: drains an 8-bit vector into one 3-bit index per handshake beat
module encoder83_serial
    import encoder83_serial_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input logic                clk,
    input logic                rst,
    encoder83_serial_if.slave  bus
);
    state_t             r_state;
    logic [VEC_W-1:0]   r_pend;
    logic               r_zero;
    logic [3:0]         r_pop;
    logic [CODE_W-1:0]  w_code;
    logic [VEC_W-1:0]   w_mask;
    logic               w_single;

    prio_enc8 #(.LSB_FIRST(LSB_FIRST)) u_prio (
        .i_pend   (r_pend),
        .o_code   (w_code),
        .o_mask   (w_mask),
        .o_single (w_single)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pend  <= '0;
            r_zero  <= 1'b0;
            r_pop   <= '0;
        end else begin
            r_zero <= 1'b0;
            case (r_state)
                ST_IDLE: if (bus.in_valid) begin
                    r_pend  <= bus.in_vec;
                    r_pop   <= popcount8(bus.in_vec);
                    r_zero  <= bus.in_vec == '0;
                    r_state <= bus.in_vec != '0 ? ST_EMIT : ST_IDLE;
                end
                ST_EMIT: if (bus.out_ready) begin
                    r_pend  <= r_pend & ~w_mask;
                    r_state <= w_single ? ST_IDLE : ST_EMIT;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_state == ST_IDLE;
    assign bus.out_valid = r_state == ST_EMIT;
    assign bus.out_code  = w_code;
    assign bus.out_last  = w_single;
    assign bus.zero_flag = r_zero;
    assign bus.pop_cnt   = r_pop;
endmodule

// File: tb/tb_encoder83_serial.sv
// tb_encoder83_serial: LSB-first and MSB-first instances driven in lockstep, checked against a bit-list model
module tb_encoder83_serial;
    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       out_ready;
    int         n_cmp;
    int         n_err;

    encoder83_serial_if if_l ();
    encoder83_serial_if if_m ();

    assign if_l.in_valid  = in_valid;
    assign if_l.in_vec    = in_vec;
    assign if_l.out_ready = out_ready;
    assign if_m.in_valid  = in_valid;
    assign if_m.in_vec    = in_vec;
    assign if_m.out_ready = out_ready;

    encoder83_serial #(.LSB_FIRST(1'b1)) u_lsb (.clk(clk), .rst(rst), .bus(if_l));
    encoder83_serial #(.LSB_FIRST(1'b0)) u_msb (.clk(clk), .rst(rst), .bus(if_m));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accept v at the next edge, then drain it; called and returns at a negedge with both DUTs idle
    task automatic send_vec(input logic [7:0] v, input int ready_pct, input int stall);
        logic [2:0] exp_l[$];
        logic [2:0] exp_m[$];
        int k, nb, cyc;
        for (int b = 0; b < 8; b++) if (v[b]) exp_l.push_back(3'(b));
        for (int b = 7; b >= 0; b--) if (v[b]) exp_m.push_back(3'(b));
        k = exp_l.size();
        n_cmp++;
        if (if_l.in_ready !== 1'b1 || if_m.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL accept_ready vec=%h got l=%b m=%b want 1", v, if_l.in_ready, if_m.in_ready);
        end
        in_valid = 1'b1;
        in_vec = v;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (if_l.pop_cnt !== 4'(k) || if_m.pop_cnt !== 4'(k) || if_l.zero_flag !== 1'b0) begin
            n_err++;
            $display("FAIL pop_cnt vec=%h got l=%0d m=%0d zf=%b want %0d zf=0", v, if_l.pop_cnt, if_m.pop_cnt, if_l.zero_flag, k);
        end
        nb = 0;
        cyc = 0;
        while (nb < k && cyc < 200) begin
            out_ready = (cyc >= stall) && ($urandom_range(99) < ready_pct);
            in_valid = 1'($urandom);
            in_vec = 8'($urandom);
            n_cmp++;
            if (if_l.out_valid !== 1'b1 || if_m.out_valid !== 1'b1 || if_l.in_ready !== 1'b0 || if_m.in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL emit_valid vec=%h beat=%0d got v=%b%b r=%b%b want v=11 r=00", v, nb,
                         if_l.out_valid, if_m.out_valid, if_l.in_ready, if_m.in_ready);
            end
            n_cmp++;
            if (if_l.out_code !== exp_l[nb] || if_m.out_code !== exp_m[nb]) begin
                n_err++;
                $display("FAIL code vec=%h beat=%0d got l=%0d m=%0d want l=%0d m=%0d", v, nb,
                         if_l.out_code, if_m.out_code, exp_l[nb], exp_m[nb]);
            end
            n_cmp++;
            if (if_l.out_last !== (nb == k-1) || if_m.out_last !== (nb == k-1)) begin
                n_err++;
                $display("FAIL last vec=%h beat=%0d got l=%b m=%b want %b", v, nb, if_l.out_last, if_m.out_last, nb == k-1);
            end
            if (out_ready) nb++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (nb != k) begin
            n_err++;
            $display("FAIL drain_timeout vec=%h got beats=%0d want %0d", v, nb, k);
        end
        in_valid = 1'b0;
        out_ready = 1'($urandom);
        n_cmp++;
        if (if_l.in_ready !== 1'b1 || if_m.in_ready !== 1'b1 || if_l.out_valid !== 1'b0 || if_m.out_valid !== 1'b0
            || if_l.pop_cnt !== 4'(k)) begin
            n_err++;
            $display("FAIL back_idle vec=%h got r=%b%b v=%b%b pop=%0d want r=11 v=00 pop=%0d", v,
                     if_l.in_ready, if_m.in_ready, if_l.out_valid, if_m.out_valid, if_l.pop_cnt, k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_vec = 8'h00;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (if_l.in_ready !== 1'b1 || if_l.out_valid !== 1'b0 || if_l.out_code !== 3'd0 || if_l.out_last !== 1'b0
            || if_l.zero_flag !== 1'b0 || if_l.pop_cnt !== 4'd0 || if_m.in_ready !== 1'b1 || if_m.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset got r=%b v=%b c=%0d l=%b z=%b p=%0d want r=1 v=0 c=0 l=0 z=0 p=0",
                     if_l.in_ready, if_l.out_valid, if_l.out_code, if_l.out_last, if_l.zero_flag, if_l.pop_cnt);
        end
    endtask

    task automatic test_order();
        send_vec(8'hA5, 100, 0);
    endtask

    task automatic test_zero();
        in_valid = 1'b1;
        in_vec = 8'h00;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (if_l.zero_flag !== 1'b1 || if_m.zero_flag !== 1'b1 || if_l.out_valid !== 1'b0 || if_l.pop_cnt !== 4'd0
            || if_l.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL zero_pulse got z=%b%b v=%b p=%0d r=%b want z=11 v=0 p=0 r=1",
                     if_l.zero_flag, if_m.zero_flag, if_l.out_valid, if_l.pop_cnt, if_l.in_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (if_l.zero_flag !== 1'b0 || if_m.zero_flag !== 1'b0 || if_l.out_valid !== 1'b0 || if_m.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL zero_end got z=%b%b v=%b%b want z=00 v=00", if_l.zero_flag, if_m.zero_flag, if_l.out_valid, if_m.out_valid);
        end
    endtask

    task automatic test_extremes();
        send_vec(8'hFF, 100, 0);
        send_vec(8'h80, 100, 0);
        send_vec(8'h01, 100, 0);
    endtask

    task automatic test_backpressure();
        send_vec(8'h12, 100, 3);
    endtask

    task automatic test_back_to_back();
        for (int v = 1; v < 256; v++) send_vec(8'(v), 60, 0);
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        in_vec = 8'hA5;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (if_l.out_valid !== 1'b1 || if_l.out_code !== 3'd5) begin
            n_err++;
            $display("FAIL pre_reset got v=%b c=%0d want v=1 c=5", if_l.out_valid, if_l.out_code);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (if_l.out_valid !== 1'b0 || if_m.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset got v=%b%b want 00", if_l.out_valid, if_m.out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (if_l.in_ready !== 1'b1 || if_l.pop_cnt !== 4'd0 || if_m.pop_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL post_reset got r=%b p=%0d/%0d want r=1 p=0", if_l.in_ready, if_l.pop_cnt, if_m.pop_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (if_l.out_valid !== 1'b0 || if_m.out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL no_beats cyc=%0d got v=%b%b want 00", i, if_l.out_valid, if_m.out_valid);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_order();
        test_zero();
        test_extremes();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
